ixc_ptx_call_responder: RTL
===========================

// Module: ixc_ptx_call_responder
// PURPOSE
//  Responder end of the PTX call/return transport. Accepts one-cycle call events
//  (callEv + tag) from the DUT-side PTX initiator and queues them in a FIFO.
//  Serves each call by a req/ack handshake with the host-side service logic,
//  then answers with a one-cycle xptRtn pulse that carries the same tag.
//  Sits on the uClk domain between the PTX initiator and the host service port.
// PARAMETERS
//  DEPTH    4    pending-call FIFO entries (power of 2, >=2)
//  TAG_W    8    call tag width
//  CNT_W    3    pendCnt width, equal to clog2(DEPTH)+1
//  TIMEOUT  64   host-ack timeout in cycles (used only when IXC_PTX_TIMEOUT_EN is defined)
// PORTS
//  uClk      in   1      single clock; all logic is posedge
//  uRst      in   1      reset, asynchronous, active-high
//  callEvOn  in   1      call acceptance enable
//  callEv    in   1      one-cycle call event
//  callTag   in   TAG_W  tag of the call, sampled together with callEv
//  dly       in   2      return delay in cycles (0..3), sampled when an entry is popped
//  hasPTX    out  1      responder present; 0 in reset, 1 from the first cycle after reset
//  callFull  out  1      FIFO full
//  callOvf   out  1      sticky: a call was dropped; cleared only by reset
//  pendCnt   out  CNT_W  number of queued calls, not counting the one in service
//  hostReq   out  1      service request; level, held until hostAck
//  hostTag   out  TAG_W  tag of the call in service, valid while hostReq=1
//  hostAck   in   1      service done
//  xptRtn    out  1      one-cycle return pulse
//  rtnTag    out  TAG_W  tag of the returned call, valid when xptRtn=1
//  rtnErr    out  1      return caused by timeout, valid when xptRtn=1
// BEHAVIOUR
//  Reset values: all outputs 0. FIFO is empty, pointers are 0, FSM is in IDLE.
//  Push: on callEv & callEvOn & (!callFull | pop in the same cycle).
//  - callEv & callEvOn & callFull with no pop in that cycle: the call is dropped
//    and callOvf is set.
//  - callEv with callEvOn=0: ignored; no overflow flag.
//  Push and pop in the same cycle: pendCnt is unchanged. Pointers wrap modulo DEPTH.
//  FSM states IDLE, WAIT, REQ, RTN:
//   IDLE  pendCnt!=0: pop the head into cur_tag and load dcnt<=dly.
//         Next state is WAIT if dly!=0, else REQ.
//   WAIT  dcnt decrements each cycle; go to REQ in the cycle dcnt==1.
//   REQ   hostReq=1, hostTag=cur_tag. hostAck=1 -> RTN.
//         hostAck is ignored in every other state.
//   RTN   xptRtn=1, rtnTag=cur_tag for exactly one cycle, then IDLE.
//  Min latency (empty FIFO, dly=0, ack in the first REQ cycle):
//   callEv at cycle T -> hostReq at T+2 -> xptRtn at T+3.
//  Returns are strictly in call order. At most one call is in service.
//  back-to-back returns are spaced >=3 cycles apart (IDLE, REQ, RTN).
//  Reset asserted mid-operation: the in-service call and all queued calls are
//  discarded with no xptRtn. hasPTX drops to 0 asynchronously.
// CONFIGURATION
//  IXC_PTX_TIMEOUT_EN defined:
//   - REQ counts cycles; if TIMEOUT cycles pass with no hostAck, go to RTN with
//     rtnErr=1. hostReq deasserts on leaving REQ.
//   - hostAck in the same cycle as the timeout wins and gives rtnErr=0.
//  IXC_PTX_TIMEOUT_EN undefined:
//   - no timeout counter; REQ waits indefinitely.
//   - rtnErr is tied to 0.
// TESTING
//  1 Reset release, dly=0, callEv tag=0x11 at T, hostAck tied 1
//    -> hostReq at T+2, xptRtn with rtnTag=0x11 at T+3, exactly one pulse.
//  2 dly=3, single call tag=0x22, hostAck tied 1
//    -> hostReq at T+5, xptRtn at T+6.
//  3 DEPTH=4: five calls 0x01..0x05 on consecutive cycles, hostAck=0
//    -> 0x01 goes into service and 0x02..0x05 are queued, pendCnt=4, callFull=1,
//       callOvf=0. A sixth call 0x06 -> dropped, callOvf=1.
//       Then acks -> returns 0x01..0x05 in order.
//  4 FIFO full; in the IDLE pop cycle drive callEv tag=0x33
//    -> push accepted, callOvf unchanged, pendCnt stays DEPTH.
//  5 Assert uRst while in REQ with 2 queued calls
//    -> hostReq=0 and pendCnt=0 immediately; no xptRtn after release.
//  6 With IXC_PTX_TIMEOUT_EN, TIMEOUT=64, hostAck=0
//    -> xptRtn with rtnErr=1, 64 cycles after hostReq rose.
//       Ack in the 64th cycle -> rtnErr=0.

Source files
------------

// File: rtl/ixc_ptx_call_responder.sv
`default_nettype none
// ============================================================================
// Module      : ixc_ptx_call_responder
// Description : Responder end of the PTX call/return transport. Queues call
//               events in a small FIFO and serves them one at a time through
//               a req/ack handshake with the host service logic. It answers
//               each call with a one-cycle xptRtn pulse carrying the call tag.
//               Optional feature macro: IXC_PTX_TIMEOUT_EN (host-ack timeout)
// Revision    : 1.0  initial release
// ============================================================================
module ixc_ptx_call_responder #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic             uClk,
    input  logic             uRst,
    input  logic             callEvOn,
    input  logic             callEv,
    input  logic [TAG_W-1:0] callTag,
    input  logic [1:0]       dly,
    output logic             hasPTX,
    output logic             callFull,
    output logic             callOvf,
    output logic [CNT_W-1:0] pendCnt,
    output logic             hostReq,
    output logic [TAG_W-1:0] hostTag,
    input  logic             hostAck,
    output logic             xptRtn,
    output logic [TAG_W-1:0] rtnTag,
    output logic             rtnErr
);

    localparam int              c_PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_RTN  = 2'd3
    } state_t;

    logic [TAG_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic               r_hasPtx;

    state_t             r_state;
    logic [TAG_W-1:0]   r_curTag;
    logic [1:0]         r_dcnt;
    logic               r_hostReq;
    logic [TAG_W-1:0]   r_hostTag;
    logic               r_xptRtn;
    logic [TAG_W-1:0]   r_rtnTag;

    logic w_full;
    logic w_pop;
    logic w_callOk;
    logic w_push;
    logic w_drop;
    logic w_timeout;

    // A pop frees a slot in the same cycle, so a call arriving while full is
    // still accepted when the engine is taking the head at that moment.
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_pop    = (r_state == ST_IDLE) && (r_count != '0);
    assign w_callOk = callEv & callEvOn;
    assign w_push   = w_callOk & (~w_full | w_pop);
    assign w_drop   = w_callOk & w_full & ~w_pop;

`ifdef IXC_PTX_TIMEOUT_EN
    localparam int               c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic [c_TO_W-1:0] r_toCnt;
    logic              r_rtnErr;

    // Host-ack timeout: counts REQ cycles, value k-1 in the k-th REQ cycle
    always_ff @(posedge uClk or posedge uRst) begin
        if (uRst) begin
            r_toCnt <= '0;
        end else if (r_state != ST_REQ) begin
            r_toCnt <= '0;
        end else if (!w_timeout) begin
            r_toCnt <= r_toCnt + c_TO_W'(1);
        end
    end

    assign w_timeout = (r_toCnt == c_TO_LAST);
    assign rtnErr    = r_rtnErr;
`else
    logic w_unusedTimeout;
    assign w_unusedTimeout = (TIMEOUT != 0);
    assign w_timeout       = 1'b0;
    assign rtnErr          = 1'b0;
`endif

    // Pending-call storage; contents need no reset since the count gates reads
    always_ff @(posedge uClk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= callTag;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and presence flag
    always_ff @(posedge uClk or posedge uRst) begin
        if (uRst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_hasPtx <= 1'b0;
        end else begin
            r_hasPtx <= 1'b1;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Service engine: pop, optional delay, host handshake, return pulse
    always_ff @(posedge uClk or posedge uRst) begin
        if (uRst) begin
            r_state   <= ST_IDLE;
            r_curTag  <= '0;
            r_dcnt    <= '0;
            r_hostReq <= 1'b0;
            r_hostTag <= '0;
            r_xptRtn  <= 1'b0;
            r_rtnTag  <= '0;
`ifdef IXC_PTX_TIMEOUT_EN
            r_rtnErr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_curTag <= r_mem[r_rdPtr];
                        r_dcnt   <= dly;
                        if (dly != 2'd0) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state   <= ST_REQ;
                            r_hostReq <= 1'b1;
                            r_hostTag <= r_mem[r_rdPtr];
                        end
                    end
                end
                ST_WAIT: begin
                    r_dcnt <= r_dcnt - 2'd1;
                    if (r_dcnt == 2'd1) begin
                        r_state   <= ST_REQ;
                        r_hostReq <= 1'b1;
                        r_hostTag <= r_curTag;
                    end
                end
                ST_REQ: begin
                    // An ack coinciding with the timeout counts as a normal return
                    if (hostAck || w_timeout) begin
                        r_state   <= ST_RTN;
                        r_hostReq <= 1'b0;
                        r_xptRtn  <= 1'b1;
                        r_rtnTag  <= r_curTag;
`ifdef IXC_PTX_TIMEOUT_EN
                        r_rtnErr  <= ~hostAck;
`endif
                    end
                end
                ST_RTN: begin
                    r_state  <= ST_IDLE;
                    r_xptRtn <= 1'b0;
`ifdef IXC_PTX_TIMEOUT_EN
                    r_rtnErr <= 1'b0;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hasPTX   = r_hasPtx;
    assign callFull = w_full;
    assign callOvf  = r_ovf;
    assign pendCnt  = r_count;
    assign hostReq  = r_hostReq;
    assign hostTag  = r_hostTag;
    assign xptRtn   = r_xptRtn;
    assign rtnTag   = r_rtnTag;

endmodule
`default_nettype wire
